// File: rtl/processor_pkg.sv
// Shared types and constants for the multi-cycle processor core:
// FSM state encoding, opcodes, instruction field positions and sizes.
package processor_pkg;

    localparam int RF_DEPTH = 16;
    localparam int RF_AW    = 4;
    localparam int DADDR_W  = 8;
    localparam int IR_W     = 16;

    // Instruction field positions
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int RA_MSB    = 11;
    localparam int RA_LSB    = 8;
    localparam int RB_MSB    = 7;
    localparam int RB_LSB    = 4;
    localparam int RD_MSB    = 3;
    localparam int RD_LSB    = 0;
    localparam int SADDR_MSB = 7;
    localparam int SADDR_LSB = 0;
    localparam int LADDR_MSB = 11;
    localparam int LADDR_LSB = 4;

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC   = 4'd3,
        MEM    = 4'd4,
        HALT   = 4'd5
    } state_e;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_JMP   = 4'd6
    } opcode_e;

endpackage

// File: rtl/proc_regfile.sv
// 16-entry register file: two asynchronous read ports, one synchronous
// write port, whole array cleared by the asynchronous reset.
module proc_regfile
    import processor_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [RF_AW-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RF_AW-1:0]  i_raddr_a,
    input  logic [RF_AW-1:0]  i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [RF_DEPTH];

    // Register array: cleared on reset, single write per cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see the pre-write contents during a write cycle
    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/processor_core.sv
// Multi-cycle processor core: FSM controller, PC/IR, ALU and register file.
// External combinational instruction ROM and req/ack data memory.
// Optional performance counters enabled by defining PROC_PERF_CNT_EN.
module processor_core
    import processor_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 7
) (
    input  logic               Clk,
    input  logic               ResetN,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [IR_W-1:0]    imem_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic               halted,
    output logic [3:0]         State,
    output logic [IR_W-1:0]    IR_Out,
    output logic [PC_W-1:0]    PC_Out,
    output logic [DATA_W-1:0]  ALU_A,
    output logic [DATA_W-1:0]  ALU_B,
    output logic [DATA_W-1:0]  ALU_Out
`ifdef PROC_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        retired_cnt
`endif
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_e               r_state;
    state_e               w_next_state;
    logic [PC_W-1:0]      r_pc;
    logic [IR_W-1:0]      r_ir;
    logic [3:0]           w_op;
    logic [DATA_W-1:0]    w_rd_a;
    logic [DATA_W-1:0]    w_rd_b;
    logic [DATA_W-1:0]    w_alu_out;
    logic                 w_rf_we;
    logic [DATA_W-1:0]    w_rf_wdata;
    logic                 w_dmem_req;
    logic                 w_dmem_we;
    logic [DADDR_W-1:0]   w_dmem_addr;
    logic [DATA_W-1:0]    w_dmem_wdata;

    assign w_op = r_ir[OP_MSB:OP_LSB];

    proc_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .i_clk     (Clk),
        .i_rst_n   (ResetN),
        .i_we      (w_rf_we),
        .i_waddr   (r_ir[RD_MSB:RD_LSB]),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (r_ir[RA_MSB:RA_LSB]),
        .i_raddr_b (r_ir[RB_MSB:RB_LSB]),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // ALU: only ADD and SUB results are ever written back
    assign w_alu_out = (w_op == OP_SUB) ? (w_rd_a - w_rd_b) : (w_rd_a + w_rd_b);

    // State register
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus memory-port and register-file write controls
    always_comb begin
        w_next_state = r_state;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_dmem_addr  = '0;
        w_dmem_wdata = '0;
        w_rf_we      = 1'b0;
        w_rf_wdata   = w_alu_out;
        case (r_state)
            INIT:   w_next_state = FETCH;
            FETCH:  w_next_state = DECODE;
            DECODE: begin
                case (w_op)
                    OP_ADD, OP_SUB:   w_next_state = EXEC;
                    OP_LOAD, OP_STORE: w_next_state = MEM;
                    OP_HALT:          w_next_state = HALT;
                    default:          w_next_state = FETCH;
                endcase
            end
            EXEC: begin
                w_rf_we      = 1'b1;
                w_next_state = FETCH;
            end
            MEM: begin
                // IR and RF are untouched while waiting, so these hold steady
                w_dmem_req = 1'b1;
                if (w_op == OP_STORE) begin
                    w_dmem_we    = 1'b1;
                    w_dmem_addr  = r_ir[SADDR_MSB:SADDR_LSB];
                    w_dmem_wdata = w_rd_a;
                end else begin
                    w_dmem_addr  = r_ir[LADDR_MSB:LADDR_LSB];
                end
                if (dmem_ack) begin
                    w_next_state = FETCH;
                    if (w_op == OP_LOAD) begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = dmem_rdata;
                    end
                end
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = INIT;
        endcase
    end

    // PC and IR: fetch loads IR and increments PC, decode of JMP redirects PC
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_pc <= '0;
            r_ir <= '0;
        end else begin
            if (r_state == FETCH) begin
                r_ir <= imem_data;
                r_pc <= r_pc + PC_ONE;
            end else if (r_state == DECODE && w_op == OP_JMP) begin
                r_pc <= r_ir[PC_W-1:0];
            end
        end
    end

`ifdef PROC_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_retired_cnt;

    // Cycle and retired-instruction counters, both frozen once halted
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
        end else begin
            if (r_state != HALT) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_next_state == FETCH &&
                (r_state == DECODE || r_state == EXEC || r_state == MEM)) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign retired_cnt = r_retired_cnt;
`endif

    // Memory port is decoded from state, so reset drops dmem_req immediately
    assign dmem_req   = w_dmem_req;
    assign dmem_we    = w_dmem_we;
    assign dmem_addr  = w_dmem_addr;
    assign dmem_wdata = w_dmem_wdata;

    assign imem_addr = r_pc;
    assign halted    = (r_state == HALT);
    assign State     = r_state;
    assign IR_Out    = r_ir;
    assign PC_Out    = r_pc;
    assign ALU_A     = w_rd_a;
    assign ALU_B     = w_rd_b;
    assign ALU_Out   = w_alu_out;

endmodule

// File: tb/tb_processor_core.sv
// Directed bench for processor_core: behavioural instruction ROM and a
// variable-latency data memory, expected values computed by hand.
module tb_processor_core;

    localparam int DATA_W = 16;
    localparam int PC_W   = 7;

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC   = 4'd3;
    localparam logic [3:0] S_MEM    = 4'd4;
    localparam logic [3:0] S_HALT   = 4'd5;

    logic              Clk    = 1'b0;
    logic              ResetN = 1'b0;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;
    logic              dmem_req;
    logic              dmem_we;
    logic [7:0]        dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic              halted;
    logic [3:0]        State;
    logic [15:0]       IR_Out;
    logic [PC_W-1:0]   PC_Out;
    logic [DATA_W-1:0] ALU_A;
    logic [DATA_W-1:0] ALU_B;
    logic [DATA_W-1:0] ALU_Out;
`ifdef PROC_PERF_CNT_EN
    logic [31:0]       cycle_cnt;
    logic [31:0]       retired_cnt;
`endif

    logic [15:0]       rom  [128];
    logic [DATA_W-1:0] dmem [256];
    int                wait_n    = 0;
    logic              force_ack = 1'b0;
    int                req_cnt   = 0;
    logic [7:0]        wr_addr   = '0;
    logic [DATA_W-1:0] wr_data   = '0;
    int                wr_cnt    = 0;
    int                n_pass    = 0;
    int                n_fail    = 0;
    int                n_total   = 0;

    processor_core #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .halted     (halted),
        .State      (State),
        .IR_Out     (IR_Out),
        .PC_Out     (PC_Out),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_Out    (ALU_Out)
`ifdef PROC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    assign imem_data  = rom[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign dmem_ack   = force_ack | (dmem_req && (req_cnt >= wait_n));

    // Memory model: counts wait cycles and records completed stores
    always @(posedge Clk) begin
        if (dmem_req && !dmem_ack) req_cnt <= req_cnt + 1;
        else                       req_cnt <= 0;
        if (dmem_req && dmem_ack && dmem_we) begin
            wr_addr <= dmem_addr;
            wr_data <= dmem_wdata;
            wr_cnt  <= wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic to_fetch(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (State !== S_FETCH && n < 40);
        chk(tag, n, exp_lat);
    endtask

    task automatic mem_op(input string tag, input int waits, input logic we,
                          input logic [7:0] addr, input logic [DATA_W-1:0] wdata);
        wait_n = waits;
        tick();
        chk({tag, "_dec"}, State, S_DECODE);
        for (int i = 0; i <= waits; i++) begin
            tick();
            chk({tag, "_state"}, State, S_MEM);
            chk({tag, "_req"}, dmem_req, 1);
            chk({tag, "_we"}, dmem_we, we);
            chk({tag, "_addr"}, dmem_addr, addr);
            if (we) chk({tag, "_wdata"}, dmem_wdata, wdata);
        end
        tick();
        chk({tag, "_done"}, State, S_FETCH);
    endtask

    task automatic alu_op(input string tag, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] res);
        tick();
        chk({tag, "_dec"}, State, S_DECODE);
        tick();
        chk({tag, "_state"}, State, S_EXEC);
        chk({tag, "_a"}, ALU_A, a);
        chk({tag, "_b"}, ALU_B, b);
        chk({tag, "_out"}, ALU_Out, res);
        tick();
        chk({tag, "_done"}, State, S_FETCH);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        dmem[8'h10] = 16'd5;
        dmem[8'h11] = 16'd7;
        rom[0]  = 16'h2101;   // LOAD  R1 <- D[0x10]
        rom[1]  = 16'h2112;   // LOAD  R2 <- D[0x11]
        rom[2]  = 16'h6005;   // JMP   5
        rom[3]  = 16'h5000;   // HALT (skipped)
        rom[4]  = 16'h5000;   // HALT (skipped)
        rom[5]  = 16'h3123;   // ADD   R3 = R1 + R2
        rom[6]  = 16'h1312;   // STORE D[0x12] <- R3
        rom[7]  = 16'h4124;   // SUB   R4 = R1 - R2
        rom[8]  = 16'hF000;   // opcode 15 -> NOOP
        rom[9]  = 16'h3111;   // ADD   R1 = R1 + R1
        rom[10] = 16'h1113;   // STORE D[0x13] <- R1
        rom[11] = 16'h1414;   // STORE D[0x14] <- R4
        rom[12] = 16'h607E;   // JMP   0x7E

        // Reset values
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_state", State, S_INIT);
        chk("rst_pc", PC_Out, 0);
        chk("rst_ir", IR_Out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_daddr", dmem_addr, 0);
        chk("rst_alu", ALU_Out, 0);

        @(negedge Clk);
        ResetN = 1'b1;
        #1;
        chk("init_hold", State, S_INIT);
        tick();
        chk("init_to_fetch", State, S_FETCH);
        chk("fetch_addr0", imem_addr, 0);

        // Loads: ack in first cycle, then 3 cycles late
        mem_op("ld1", 0, 1'b0, 8'h10, '0);
        chk("ld1_pc", PC_Out, 1);
        mem_op("ld2", 3, 1'b0, 8'h11, '0);
        chk("ld2_pc", PC_Out, 2);

        // Jump over the HALTs
        to_fetch("jmp_lat", 2);
        chk("jmp_target", imem_addr, 5);

        alu_op("add", 16'd5, 16'd7, 16'd12);
        chk("add_pc", PC_Out, 6);

        mem_op("st12", 1, 1'b1, 8'h12, 16'd12);
        chk("st12_waddr", wr_addr, 8'h12);
        chk("st12_wdata", wr_data, 16'd12);

        alu_op("sub", 16'd5, 16'd7, 16'hFFFE);
        chk("sub_pc", PC_Out, 8);

        to_fetch("illegal_lat", 2);
        chk("illegal_pc", PC_Out, 9);

        // Same register as both operands and destination
        alu_op("add_same", 16'd5, 16'd5, 16'd10);
        mem_op("st13", 0, 1'b1, 8'h13, 16'd10);
        chk("st13_wdata", wr_data, 16'd10);
        mem_op("st14", 2, 1'b1, 8'h14, 16'hFFFE);
        chk("st14_waddr", wr_addr, 8'h14);
        chk("st_count", wr_cnt, 3);

        // PC wrap at the top of instruction space
        to_fetch("jmp7e_lat", 2);
        chk("jmp7e_pc", PC_Out, 7'h7E);
        to_fetch("nop7e_lat", 2);
        chk("nop7e_pc", PC_Out, 7'h7F);
        to_fetch("nop7f_lat", 2);
        chk("wrap_pc", PC_Out, 0);
        chk("wrap_addr", imem_addr, 0);

        // Reset in the middle of a stalled LOAD
        wait_n = 100;
        tick();
        chk("abort_dec", State, S_DECODE);
        tick();
        chk("abort_in_mem", State, S_MEM);
        chk("abort_req_hi", dmem_req, 1);
        #3;
        ResetN = 1'b0;
        #1;
        chk("abort_req_lo", dmem_req, 0);
        chk("abort_state", State, S_INIT);
        chk("abort_pc", PC_Out, 0);

        rom[0] = 16'h3125;    // ADD  R5 = R1 + R2 (both cleared)
        rom[1] = 16'h5000;    // HALT
        rom[2] = 16'h2101;
        wait_n = 0;
        @(negedge Clk);
        ResetN = 1'b1;
        tick();
        chk("rst2_fetch", State, S_FETCH);
        alu_op("rf_clear", 16'd0, 16'd0, 16'd0);

        // HALT is absorbing and ignores stray acks
        tick();
        chk("halt_dec", State, S_DECODE);
        tick();
        chk("halt_state", State, S_HALT);
        chk("halt_flag", halted, 1);
`ifdef PROC_PERF_CNT_EN
        chk("perf_retired", retired_cnt, 1);
        chk("perf_cycles", cycle_cnt, 6);
`endif
        force_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_hold", State, S_HALT);
            chk("halt_flag_hold", halted, 1);
            chk("halt_no_req", dmem_req, 0);
            chk("halt_pc", PC_Out, 2);
`ifdef PROC_PERF_CNT_EN
            chk("perf_cycles_frozen", cycle_cnt, 6);
`endif
        end
        force_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
